// File: rtl/decode_imm_controller.sv
// decode_imm_controller
//
// Decode-stage sequencing controller for the RV32IM pipeline. Fetched beats
// arrive over a valid/ready handshake. Each beat's opcode is decoded into the
// immediate-format code for the immediate generation unit, and illegal
// opcodes are flagged. Decoded beats are held in a two-entry elastic buffer
// (main + skid), so that back-pressure from execute never drops or reorders a
// beat. A saturating counter tracks illegal beats handed downstream.
//
// Ports:
//   CLK              clock, all state updates on rising edge
//   RESET            synchronous active-high reset (overrides FLUSH)
//   FLUSH            synchronous pipeline flush, empties both entries
//   IN_VALID         fetch beat valid
//   IN_READY         controller can accept a beat (registered, = ~skid valid)
//   IN_INSTRUCTION   fetched instruction word
//   IN_PC            PC of fetched instruction
//   OUT_VALID        main entry holds a decoded beat
//   OUT_READY        downstream accepts the main entry this cycle
//   OUT_INSTRUCTION  instruction of main entry
//   OUT_PC           PC of main entry
//   IMM_SELECT       immediate format code of main entry
//   OUT_ILLEGAL      main entry is an illegal encoding
//   ILLEGAL_COUNT    saturating count of illegal beats popped downstream

module decode_imm_controller #(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FLUSH,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [31:0]            IN_INSTRUCTION,
    input  logic [31:0]            IN_PC,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [31:0]            OUT_INSTRUCTION,
    output logic [31:0]            OUT_PC,
    output logic [2:0]             IMM_SELECT,
    output logic                   OUT_ILLEGAL,
    output logic [COUNT_WIDTH-1:0] ILLEGAL_COUNT
);

    typedef enum logic [2:0] {
        FMT_U    = 3'b000,
        FMT_J    = 3'b001,
        FMT_I    = 3'b010,
        FMT_B    = 3'b011,
        FMT_S    = 3'b100,
        FMT_NONE = 3'b111
    } imm_fmt_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    // Decode of the incoming beat
    imm_fmt_e in_sel;
    logic     in_ill;

    always_comb begin
        in_sel = FMT_NONE;
        in_ill = 1'b0;
        case (IN_INSTRUCTION[6:0])
            OPC_LUI, OPC_AUIPC:              in_sel = FMT_U;
            OPC_JAL:                         in_sel = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:  in_sel = FMT_I;
            OPC_BRANCH:                      in_sel = FMT_B;
            OPC_STORE:                       in_sel = FMT_S;
            OPC_OP:                          in_sel = FMT_NONE;
            default: begin
                in_sel = FMT_NONE;
                in_ill = 1'b1;
            end
        endcase
    end

    // Main entry (drives outputs) and skid entry
    logic                   main_valid, main_valid_nxt;
    logic [31:0]            main_instr, main_instr_nxt;
    logic [31:0]            main_pc,    main_pc_nxt;
    imm_fmt_e               main_sel,   main_sel_nxt;
    logic                   main_ill,   main_ill_nxt;

    logic                   skid_valid, skid_valid_nxt;
    logic [31:0]            skid_instr, skid_instr_nxt;
    logic [31:0]            skid_pc,    skid_pc_nxt;
    imm_fmt_e               skid_sel,   skid_sel_nxt;
    logic                   skid_ill,   skid_ill_nxt;

    logic [COUNT_WIDTH-1:0] count, count_nxt;

    logic accept;
    logic pop;

    assign IN_READY = ~skid_valid;
    assign accept   = IN_VALID & ~skid_valid;
    assign pop      = main_valid & OUT_READY;

    always_comb begin
        main_valid_nxt = main_valid;
        main_instr_nxt = main_instr;
        main_pc_nxt    = main_pc;
        main_sel_nxt   = main_sel;
        main_ill_nxt   = main_ill;
        skid_valid_nxt = skid_valid;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        skid_sel_nxt   = skid_sel;
        skid_ill_nxt   = skid_ill;
        count_nxt      = count;

        // A pop is counted even when it coincides with a flush
        if (pop && main_ill && (count != '1)) begin
            count_nxt = count + COUNT_WIDTH'(1);
        end

        if (!main_valid || pop) begin
            if (skid_valid) begin
                // Skid is older than any incoming beat, so it always goes first
                main_valid_nxt = 1'b1;
                main_instr_nxt = skid_instr;
                main_pc_nxt    = skid_pc;
                main_sel_nxt   = skid_sel;
                main_ill_nxt   = skid_ill;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                main_valid_nxt = 1'b1;
                main_instr_nxt = IN_INSTRUCTION;
                main_pc_nxt    = IN_PC;
                main_sel_nxt   = in_sel;
                main_ill_nxt   = in_ill;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            // Main is held; accept implies skid is free
            skid_valid_nxt = 1'b1;
            skid_instr_nxt = IN_INSTRUCTION;
            skid_pc_nxt    = IN_PC;
            skid_sel_nxt   = in_sel;
            skid_ill_nxt   = in_ill;
        end

        if (FLUSH) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            main_sel   <= FMT_NONE;
            main_ill   <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_sel   <= FMT_NONE;
            skid_ill   <= 1'b0;
            count      <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            main_instr <= main_instr_nxt;
            main_pc    <= main_pc_nxt;
            main_sel   <= main_sel_nxt;
            main_ill   <= main_ill_nxt;
            skid_valid <= skid_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_sel   <= skid_sel_nxt;
            skid_ill   <= skid_ill_nxt;
            count      <= count_nxt;
        end
    end

    assign OUT_VALID       = main_valid;
    assign OUT_INSTRUCTION = main_instr;
    assign OUT_PC          = main_pc;
    assign IMM_SELECT      = main_sel;
    assign OUT_ILLEGAL     = main_ill;
    assign ILLEGAL_COUNT   = count;

endmodule

// File: doc/decode_imm_controller.md
# decode_imm_controller

Decode-stage sequencing controller for the RV32IM pipeline. It accepts fetched instructions through a valid/ready handshake, decodes the opcode into the 3-bit format code that drives the SELECT input of the immediate generation unit, and flags illegal encodings. It holds each decoded instruction in a two-entry elastic buffer (main plus skid), so back-pressure from execute never drops or reorders a beat. It sits between the IF/ID register and the immediate generation unit / ID-EX register, and keeps a saturating count of retired illegal instructions.

## Interface
- COUNT_WIDTH, 8, width of the illegal-instruction counter
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- FLUSH  input  1  synchronous pipeline flush (branch/jump redirect)
- IN_VALID  input  1  fetch beat valid
- IN_READY  output  1  controller can accept a beat this cycle
- IN_INSTRUCTION  input  32  fetched instruction word
- IN_PC  input  32  PC of fetched instruction
- OUT_VALID  output  1  main entry holds a decoded beat
- OUT_READY  input  1  downstream accepts beat this cycle
- OUT_INSTRUCTION  output  32  instruction of main entry; feeds immediate generation unit INSTRUCTION
- OUT_PC  output  32  PC of main entry
- IMM_SELECT  output  3  format code of main entry; feeds immediate generation unit SELECT
- OUT_ILLEGAL  output  1  main entry is an illegal encoding
- ILLEGAL_COUNT  output  COUNT_WIDTH  saturating count of illegal beats handed downstream

## Operation
- Decode at input (combinational on IN_INSTRUCTION[6:0]), stored with the beat:
  - 0110111 LUI, 0010111 AUIPC -> 000 (U)
  - 1101111 JAL -> 001 (J)
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM -> 010 (I)
  - 1100011 BRANCH -> 011 (B)
  - 0100011 STORE -> 100 (S)
  - 0110011 OP (incl. M-extension) -> 111, legal, no immediate (generator outputs 0)
  - Any other opcode -> 111, ILLEGAL=1.
- Storage: main entry (drives outputs) and skid entry, each with its own valid bit, instruction, PC, select, and illegal bit.
- IN_READY = ~skid_valid. It is registered-derived, with no combinational path from OUT_READY.
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- Next-state rules, for the non-flush case:
  - Main empty, or popping: main loads skid if skid valid, else the accepted beat, else goes empty.
  - Skid loads the accepted beat when it cannot go to main (main valid, and either not popping or skid already occupied).
  - Skid clears when its content moves to main.
- Ordering is strictly FIFO: a beat never overtakes the one in skid.
- ILLEGAL_COUNT increments by 1 on pop with OUT_ILLEGAL=1, and saturates at 2^COUNT_WIDTH-1.
- FLUSH clears main_valid and skid_valid. A beat accepted in the same cycle is discarded. A pop in the same cycle is still counted (downstream already took it).
- RESET clears everything; RESET overrides FLUSH.

## Timing
- Latency: a beat accepted at edge N appears on OUT_* after edge N (1 cycle), provided main was empty or popping.
- Throughput: 1 beat/cycle while OUT_READY=1.
- Stall: OUT_READY low with main full. The first following accepted beat goes to skid, and IN_READY falls the next cycle. When OUT_READY rises, skid moves to main on that edge and IN_READY returns to 1 the following cycle.
- Outputs hold stable while OUT_VALID=1 and OUT_READY=0.
- IMM_SELECT changes only on clock edges. Consumers sample the immediate one cycle after the edge, which absorbs the generator's #1 output delay.
- Reset values: OUT_VALID 0, IN_READY 1, OUT_INSTRUCTION 0, OUT_PC 0, IMM_SELECT 111, OUT_ILLEGAL 0, ILLEGAL_COUNT 0, skid empty.
- After FLUSH at edge N: OUT_VALID=0 and IN_READY=1 in cycle N+1.
- Reset mid-stall discards both entries without counting.

## Test plan
- Streaming with OUT_READY=1: feed LUI, JAL, LOAD, BRANCH, STORE, ADD on consecutive cycles -> one cycle later, IMM_SELECT sequence 000, 001, 010, 011, 100, 111; OUT_ILLEGAL all 0; OUT_PC matches.
- Back-pressure: OUT_READY=0 for 3 cycles while IN_VALID=1 with PCs 0x0, 0x4, 0x8 -> main=0x0, skid=0x4, IN_READY=0, and 0x8 is held by fetch. Release -> outputs 0x0, 0x4, 0x8 in order with no loss.
- Illegal path: opcode 1111111 followed by 0001111 -> OUT_ILLEGAL=1 with IMM_SELECT=111 each; ILLEGAL_COUNT 0 -> 1 -> 2 on pops. With COUNT_WIDTH=2, 5 illegal pops -> count stays at 3.
- Flush: both entries full (one illegal), FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0 and IN_READY=1, the new beat is not visible, and the count is unchanged unless a pop coincided.
- Simultaneous pop+flush: main holds an illegal beat, OUT_READY=1, FLUSH=1 -> count +1 and both entries empty.
- Reset: assert RESET during a stall with both entries full -> next cycle all outputs equal their reset values and the count is 0.
